// File: rtl/mips_dcache.sv
// Direct-mapped write-through, write-allocate data cache for the MIPS core.
// Stalls the core on read misses and stores until memory latency elapses.
module mips_dcache #(
    parameter int NUM_LINES   = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        cache_en,
    input  logic        cache_we,
    input  logic [31:0] cache_addr,
    input  logic [31:0] cache_data_in,
    output logic [31:0] cache_data_out,
    output logic        hit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_write_en,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
);

    localparam int IB = $clog2(NUM_LINES);
    localparam int TW = 30 - IB;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]        r_cnt;
    logic [NUM_LINES-1:0] r_valid;
    logic [TW-1:0]        r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES];
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_data;
    logic                 r_mem_we;
    logic                 r_refill;
    logic [31:0]          r_hits;
    logic [31:0]          r_misses;

    logic [IB-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic [IB-1:0] w_fidx;
    logic [TW-1:0] w_ftag;
    logic          w_match;
    logic          w_last;
    logic          w_hit;
    logic          w_alloc;
    logic          w_fill;
    logic          w_unused;

    assign w_idx    = cache_addr[IB+1:2];
    assign w_tag    = cache_addr[31:IB+2];
    // Refill index/tag come from the latched address, not the live inputs
    assign w_fidx   = r_mem_addr[IB+1:2];
    assign w_ftag   = r_mem_addr[31:IB+2];
    assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last   = (r_cnt == LAST);
    assign w_unused = ^cache_addr[1:0];

    always_comb begin
        w_next  = r_state;
        w_hit   = 1'b0;
        w_alloc = 1'b0;
        w_fill  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cache_en) begin
                    if (cache_we) begin
                        w_next  = S_WRITE;
                        w_alloc = 1'b1;
                    end else if (w_match) begin
                        w_hit = 1'b1;
                    end else begin
                        w_next = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (w_last) begin
                    w_next = S_IDLE;
                    w_fill = 1'b1;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_next = S_IDLE;
                    w_hit  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_valid    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
            r_refill   <= 1'b0;
            r_hits     <= '0;
            r_misses   <= '0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= 1'b0;
            r_refill <= 1'b0;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (w_next != S_IDLE) begin
                    r_mem_addr <= {cache_addr[31:2], 2'b00};
                end
                if (w_alloc) begin
                    r_mem_data     <= cache_data_in;
                    r_mem_we       <= 1'b1;
                    r_valid[w_idx] <= 1'b1;
                end
                // The hit that completes a refill is not a clean hit
                if (w_hit && !r_refill) begin
                    r_hits <= r_hits + 32'd1;
                end
                if (w_next == S_MISS) begin
                    r_misses <= r_misses + 32'd1;
                end
            end else if (w_last) begin
                r_cnt      <= '0;
                r_mem_addr <= '0;
                if (w_fill) begin
                    r_valid[w_fidx] <= 1'b1;
                    r_refill        <= 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b && w_alloc) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= cache_data_in;
        end else if (rst_b && w_fill) begin
            r_tag[w_fidx]  <= w_ftag;
            r_data[w_fidx] <= mem_data_out;
        end
    end

    assign hit            = w_hit;
    assign cache_data_out = r_data[w_idx];
    assign mem_addr       = r_mem_addr;
    assign mem_data_in    = r_mem_data;
    assign mem_write_en   = r_mem_we;
    assign stat_hits      = r_hits;
    assign stat_misses    = r_misses;

endmodule

// File: tb/tb_mips_dcache.sv
// Bench for mips_dcache: directed scenarios plus random loads/stores
// checked against an array-level cache/memory reference model.
module tb_mips_dcache;

    localparam int LAT = 4;
    localparam int NL  = 8;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;

    logic        cache_en = 1'b0;
    logic        cache_we = 1'b0;
    logic [31:0] cache_addr = '0;
    logic [31:0] cache_data_in = '0;
    logic [31:0] cache_data_out;
    logic        hit;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out = '0;
    logic        mem_write_en;
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;

    logic        b_en = 1'b0;
    logic        b_we = 1'b0;
    logic [31:0] b_addr = '0;
    logic [31:0] b_din = '0;
    logic [31:0] b_dout;
    logic        b_hit;
    logic [31:0] b_mem_addr;
    logic [31:0] b_mem_din;
    logic [31:0] b_mem_dout;
    logic        b_mem_we;
    logic [31:0] b_hits;
    logic [31:0] b_misses;

    assign b_mem_dout = 32'hCAFE_F00D;

    always #5 clk = ~clk;

    mips_dcache #(.NUM_LINES(NL), .MEM_LATENCY(LAT)) u_dut (
        .clk(clk), .rst_b(rst_b),
        .cache_en(cache_en), .cache_we(cache_we),
        .cache_addr(cache_addr), .cache_data_in(cache_data_in),
        .cache_data_out(cache_data_out), .hit(hit),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_write_en(mem_write_en),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    mips_dcache #(.NUM_LINES(NL), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_b(rst_b),
        .cache_en(b_en), .cache_we(b_we),
        .cache_addr(b_addr), .cache_data_in(b_din),
        .cache_data_out(b_dout), .hit(b_hit),
        .mem_addr(b_mem_addr), .mem_data_in(b_mem_din),
        .mem_data_out(b_mem_dout), .mem_write_en(b_mem_we),
        .stat_hits(b_hits), .stat_misses(b_misses)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory behind the cache (written only by the DUT) and the
    // reference copy (written only by the bench's own store requests).
    logic [31:0] tbmem  [logic [31:0]];
    logic [31:0] refmem [logic [31:0]];

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] rd_tb(input logic [31:0] a);
        if (tbmem.exists(a)) return tbmem[a];
        return seed_word(a);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (refmem.exists(a)) return refmem[a];
        return seed_word(a);
    endfunction

    always @(negedge clk) mem_data_out = rd_tb(mem_addr);
    always @(posedge clk) if (mem_write_en) tbmem[mem_addr] = mem_data_in;

    bit          mvalid [NL];
    logic [31:0] mtag   [NL];
    int unsigned mhits = 0;
    int unsigned mmiss = 0;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
        mhits = 0;
        mmiss = 0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input string tag);
        int          idx;
        logic [31:0] t;
        logic [31:0] wa;
        bit          phit;
        int          expn;
        logic [31:0] expd;
        int          n;
        bit          got;
        int          wpulse;
        int          badaddr;
        logic [31:0] wa_seen;
        logic [31:0] wd_seen;
        idx  = int'((a >> 2) % NL);
        t    = a / (4 * NL);
        wa   = a & ~32'd3;
        phit = !we && mvalid[idx] && (mtag[idx] == t);
        expn = we ? LAT + 1 : (phit ? 1 : LAT + 2);
        expd = rd_ref(wa);
        n = 0; got = 0; wpulse = 0; badaddr = 0;
        wa_seen = '0; wd_seen = '0;
        @(negedge clk);
        cache_en = 1'b1; cache_we = we;
        cache_addr = a; cache_data_in = d;
        while (!got && n < LAT + 6) begin
            if (n > 0) @(negedge clk);
            #1;
            n++;
            if (mem_write_en) begin
                wpulse++;
                wa_seen = mem_addr;
                wd_seen = mem_data_in;
            end
            if (n > 1 && n <= LAT + 1) begin
                if (mem_addr !== wa) badaddr++;
            end else if (mem_addr !== 32'd0) begin
                badaddr++;
            end
            if (hit) got = 1;
        end
        chk({tag, " cycles"}, n, expn);
        chk({tag, " mem_addr bad cycles"}, badaddr, 0);
        if (we) begin
            chk({tag, " wr pulses"}, wpulse, 1);
            chk({tag, " wr addr"}, wa_seen, wa);
            chk({tag, " wr data"}, wd_seen, d);
            mvalid[idx] = 1'b1;
            mtag[idx]   = t;
            refmem[wa]  = d;
        end else begin
            chk({tag, " wr pulses"}, wpulse, 0);
            chk({tag, " load data"}, cache_data_out, expd);
            if (phit) begin
                mhits++;
            end else begin
                mmiss++;
                mvalid[idx] = 1'b1;
                mtag[idx]   = t;
            end
        end
    endtask

    task automatic chk_stats(input string tag);
        @(negedge clk);
        cache_en = 1'b0;
        #1;
        chk({tag, " hit idle"}, hit, 1'b0);
        chk({tag, " stat_hits"}, stat_hits, mhits);
        chk({tag, " stat_misses"}, stat_misses, mmiss);
    endtask

    task automatic b_req(input logic we, input logic [31:0] a,
                         input logic [31:0] d, input int expn,
                         input logic [31:0] expd, input string tag);
        int n;
        bit got;
        int wpulse;
        n = 0; got = 0; wpulse = 0;
        @(negedge clk);
        b_en = 1'b1; b_we = we; b_addr = a; b_din = d;
        while (!got && n < 8) begin
            if (n > 0) @(negedge clk);
            #1;
            n++;
            if (b_mem_we) wpulse++;
            if (b_hit) got = 1;
        end
        chk({tag, " cycles"}, n, expn);
        if (we) chk({tag, " wr pulses"}, wpulse, 1);
        else chk({tag, " load data"}, b_dout, expd);
        @(negedge clk);
        b_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        model_reset();
        tbmem[32'h100]  = 32'hDEAD_BEEF;
        refmem[32'h100] = 32'hDEAD_BEEF;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset hit", hit, 1'b0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_we", mem_write_en, 1'b0);
        chk("reset stat_hits", stat_hits, 32'd0);
        chk("reset stat_misses", stat_misses, 32'd0);
        rst_b = 1'b1;

        do_req(1'b0, 32'h100, '0, "t1 load miss");
        chk_stats("t1");
        do_req(1'b0, 32'h100, '0, "t2 load hit");
        do_req(1'b0, 32'h103, '0, "t2 load hit byte3");
        chk_stats("t2");
        do_req(1'b0, 32'h120, '0, "t3 conflict");
        do_req(1'b0, 32'h100, '0, "t3 reload");
        chk_stats("t3");
        do_req(1'b1, 32'h104, 32'h1122_3344, "t4 store");
        do_req(1'b0, 32'h104, '0, "t4 load after store");
        chk_stats("t4");

        for (int i = 0; i < 300; i++) begin
            a = 32'h100 + ($urandom_range(0, 3) << 5)
                + ($urandom_range(0, NL - 1) << 2) + $urandom_range(0, 3);
            do_req($urandom_range(0, 3) == 0, a, $urandom, "rand");
            if ($urandom_range(0, 4) == 0) chk_stats("rand idle");
        end
        chk_stats("rand end");

        @(negedge clk);
        cache_en = 1'b1; cache_we = 1'b0; cache_addr = 32'h1000;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        cache_en = 1'b0;
        @(negedge clk);
        #1;
        chk("t5 mem_addr", mem_addr, 32'd0);
        chk("t5 hit", hit, 1'b0);
        chk("t5 stat_hits", stat_hits, 32'd0);
        chk("t5 stat_misses", stat_misses, 32'd0);
        rst_b = 1'b1;
        model_reset();
        do_req(1'b0, 32'h100, '0, "t5 load after reset");
        chk_stats("t5");

        b_req(1'b0, 32'h40, '0, 3, 32'hCAFE_F00D, "t6 load miss");
        b_req(1'b1, 32'h44, 32'h5566_7788, 2, '0, "t6 store");
        b_req(1'b0, 32'h44, '0, 1, 32'h5566_7788, "t6 load hit");
        chk("t6 stat_misses", b_misses, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
